if_id_stage: RTL and testbench

IF/ID pipeline register with integrated load-use hazard detection, for the 5-stage MIPS pipeline. It captures the fetched instruction and PC+4 from IF and presents decoded register fields to ID. It generates the PC-write enable and the control-bubble select that zeroes ID/EX control inputs. It also counts stall and flush events for performance debug.

---
 rtl/if_id_stage_pkg.sv | 13 +
 rtl/if_id_stage_hazard_detect.sv | 25 ++
 rtl/if_id_stage.sv | 81 ++++++++
 tb/tb_if_id_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
// Shared pipeline definitions for the IF/ID stage: instruction field positions,
// register address width and the NOP encoding used on reset and flush.
package if_id_stage_pkg;

  localparam int REG_AW = 5;
  localparam int RS_MSB = 25;
  localparam int RT_MSB = 20;
  localparam int RD_MSB = 15;
  localparam int IMM_W  = 16;

  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use hazard detection: decides whether the PC may advance and whether
// ID/EX must receive a bubble this cycle. Purely combinational.
module hazard_detect
  import if_id_stage_pkg::*;
(
  input  logic              valid,
  input  logic              flush,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  output logic              hazard,
  output logic              pc_write,
  output logic              bubble
);

  // $zero can never carry a real dependency, and a NOP slot has no sources.
  assign hazard = valid & idex_memread & (idex_rt != '0) &
                  ((idex_rt == rs) | (idex_rt == rt));

  // A taken branch must still steer the PC even while a load-use stall is pending.
  assign pc_write = ~hazard | flush;
  assign bubble   = hazard | flush;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall control and saturating
// stall/flush event counters for performance debug.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [DATA_W-1:0] pc4_i,
  input  logic              flush_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rt_i,
  input  logic              clear_cnt_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] pc4_o,
  output logic              valid_o,
  output logic [REG_AW-1:0] rs_o,
  output logic [REG_AW-1:0] rt_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [IMM_W-1:0]  imm_o,
  output logic              pc_write_o,
  output logic              bubble_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic hazard;

  assign rs_o  = instr_o[RS_MSB -: REG_AW];
  assign rt_o  = instr_o[RT_MSB -: REG_AW];
  assign rd_o  = instr_o[RD_MSB -: REG_AW];
  assign imm_o = instr_o[IMM_W-1:0];

  hazard_detect u_hazard_detect (
    .valid        (valid_o),
    .flush        (flush_i),
    .idex_memread (idex_memread_i),
    .idex_rt      (idex_rt_i),
    .rs           (rs_o),
    .rt           (rt_o),
    .hazard       (hazard),
    .pc_write     (pc_write_o),
    .bubble       (bubble_o)
  );

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      instr_o <= DATA_W'(NOP_INSTR);
      pc4_o   <= '0;
      valid_o <= 1'b0;
    end else if (flush_i) begin
      instr_o <= DATA_W'(NOP_INSTR);
      pc4_o   <= '0;
      valid_o <= 1'b0;
    end else if (!hazard) begin
      instr_o <= instr_i;
      pc4_o   <= pc4_i;
      valid_o <= 1'b1;
    end
  end

  // Counters stick at all-ones so a long run never reports a misleadingly small count.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (clear_cnt_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (hazard && !flush_i && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_i && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed table-driven bench for if_id_stage with 2-bit counters so that
// saturation is reachable, plus a hand-written async-reset-mid-stall sequence.
module tb_if_id_stage;
  import if_id_stage_pkg::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

  localparam logic [31:0] INSTR_A = 32'h012A4020; // rs=9 rt=10 rd=8
  localparam logic [31:0] INSTR_B = 32'h8D0B0004; // rs=8 rt=11
  localparam logic [31:0] INSTR_C = 32'h00001020; // rs=0 rt=0 rd=2
  localparam logic [31:0] INSTR_D = 32'h014B6022; // rs=10 rt=11 rd=12

  logic              clk_i = 1'b0;
  logic              start_i;
  logic [DATA_W-1:0] instr_i;
  logic [DATA_W-1:0] pc4_i;
  logic              flush_i;
  logic              idex_memread_i;
  logic [REG_AW-1:0] idex_rt_i;
  logic              clear_cnt_i;
  logic [DATA_W-1:0] instr_o;
  logic [DATA_W-1:0] pc4_o;
  logic              valid_o;
  logic [REG_AW-1:0] rs_o;
  logic [REG_AW-1:0] rt_o;
  logic [REG_AW-1:0] rd_o;
  logic [IMM_W-1:0]  imm_o;
  logic              pc_write_o;
  logic              bubble_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        flush;
    logic        memread;
    logic [4:0]  idex_rt;
    logic        clear;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        exp_pw;
    logic        exp_bub;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    logic        exp_valid;
    logic [1:0]  exp_stall;
    logic [1:0]  exp_flush;
  } vec_t;

  vec_t vecs[$];

  if_id_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .start_i        (start_i),
    .instr_i        (instr_i),
    .pc4_i          (pc4_i),
    .flush_i        (flush_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .clear_cnt_i    (clear_cnt_i),
    .instr_o        (instr_o),
    .pc4_o          (pc4_o),
    .valid_o        (valid_o),
    .rs_o           (rs_o),
    .rt_o           (rt_o),
    .rd_o           (rd_o),
    .imm_o          (imm_o),
    .pc_write_o     (pc_write_o),
    .bubble_o       (bubble_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(logic fl, logic mr, logic [4:0] rt, logic clr,
                              logic [31:0] ins, logic [31:0] pc,
                              logic pw, logic bub, logic [31:0] ei, logic [31:0] ep,
                              logic ev, logic [1:0] es, logic [1:0] ef);
    vec_t v;
    v.flush = fl; v.memread = mr; v.idex_rt = rt; v.clear = clr;
    v.instr = ins; v.pc4 = pc; v.exp_pw = pw; v.exp_bub = bub;
    v.exp_instr = ei; v.exp_pc4 = ep; v.exp_valid = ev;
    v.exp_stall = es; v.exp_flush = ef;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRegs(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                           input logic ev, input logic [1:0] es, input logic [1:0] ef);
    checkOutput({tag, " instr"}, instr_o, ei);
    checkOutput({tag, " pc4"}, pc4_o, ep);
    checkOutput({tag, " valid"}, 32'(valid_o), 32'(ev));
    checkOutput({tag, " rs"}, 32'(rs_o), 32'(ei[25:21]));
    checkOutput({tag, " rt"}, 32'(rt_o), 32'(ei[20:16]));
    checkOutput({tag, " rd"}, 32'(rd_o), 32'(ei[15:11]));
    checkOutput({tag, " imm"}, 32'(imm_o), 32'(ei[15:0]));
    checkOutput({tag, " stall_cnt"}, 32'(stall_cnt_o), 32'(es));
    checkOutput({tag, " flush_cnt"}, 32'(flush_cnt_o), 32'(ef));
  endtask

  // Inputs change on the falling edge; combinational outputs are sampled before
  // the rising edge and registered outputs just after it.
  task automatic applyStimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk_i);
    flush_i        = v.flush;
    idex_memread_i = v.memread;
    idex_rt_i      = v.idex_rt;
    clear_cnt_i    = v.clear;
    instr_i        = v.instr;
    pc4_i          = v.pc4;
    #1;
    checkOutput({tag, " pc_write"}, 32'(pc_write_o), 32'(v.exp_pw));
    checkOutput({tag, " bubble"}, 32'(bubble_o), 32'(v.exp_bub));
    @(posedge clk_i);
    #1;
    checkRegs(tag, v.exp_instr, v.exp_pc4, v.exp_valid, v.exp_stall, v.exp_flush);
  endtask

  initial begin
    start_i = 1'b0;
    flush_i = 1'b0;
    idex_memread_i = 1'b0;
    idex_rt_i = '0;
    clear_cnt_i = 1'b0;
    instr_i = '0;
    pc4_i = '0;

    //    fl  mr  rt  clr instr    pc4  pw  bub exp_instr exp_pc4 ev  st fl
    vecs.push_back(mk(0, 0, 0,  0, INSTR_A, 4,  1, 0, INSTR_A, 4,  1, 0, 0)); // first load
    vecs.push_back(mk(0, 1, 9,  0, INSTR_B, 8,  0, 1, INSTR_A, 4,  1, 1, 0)); // load-use on rs
    vecs.push_back(mk(0, 0, 9,  0, INSTR_B, 8,  1, 0, INSTR_B, 8,  1, 1, 0)); // bubble drained
    vecs.push_back(mk(0, 1, 0,  0, INSTR_C, 12, 1, 0, INSTR_C, 12, 1, 1, 0)); // $zero never stalls
    vecs.push_back(mk(0, 1, 0,  0, INSTR_D, 16, 1, 0, INSTR_D, 16, 1, 1, 0)); // rs_o=0, rt=0
    vecs.push_back(mk(1, 1, 10, 0, INSTR_A, 20, 1, 1, 32'h0,   0,  0, 1, 1)); // flush beats hazard
    vecs.push_back(mk(0, 1, 0,  0, INSTR_A, 20, 1, 0, INSTR_A, 20, 1, 1, 1)); // invalid slot
    vecs.push_back(mk(0, 1, 9,  0, INSTR_B, 24, 0, 1, INSTR_A, 20, 1, 2, 1));
    vecs.push_back(mk(0, 1, 9,  0, INSTR_B, 24, 0, 1, INSTR_A, 20, 1, 3, 1));
    vecs.push_back(mk(0, 1, 9,  0, INSTR_B, 24, 0, 1, INSTR_A, 20, 1, 3, 1)); // saturated
    vecs.push_back(mk(0, 1, 9,  0, INSTR_B, 24, 0, 1, INSTR_A, 20, 1, 3, 1));
    vecs.push_back(mk(0, 1, 10, 1, INSTR_B, 24, 0, 1, INSTR_A, 20, 1, 0, 0)); // clear wins
    vecs.push_back(mk(1, 0, 0,  0, INSTR_B, 24, 1, 1, 32'h0,   0,  0, 0, 1));
    vecs.push_back(mk(1, 0, 0,  0, INSTR_B, 24, 1, 1, 32'h0,   0,  0, 0, 2));
    vecs.push_back(mk(1, 0, 0,  0, INSTR_B, 24, 1, 1, 32'h0,   0,  0, 0, 3));
    vecs.push_back(mk(1, 0, 0,  0, INSTR_B, 24, 1, 1, 32'h0,   0,  0, 0, 3)); // flush sat
    vecs.push_back(mk(0, 0, 0,  0, INSTR_A, 28, 1, 0, INSTR_A, 28, 1, 0, 3));

    // Reset state while start_i is held low across a couple of edges.
    repeat (2) @(posedge clk_i);
    #1;
    checkRegs("reset", 32'h0, 32'h0, 1'b0, 2'd0, 2'd0);
    checkOutput("reset pc_write", 32'(pc_write_o), 32'd1);
    checkOutput("reset bubble", 32'(bubble_o), 32'd0);
    @(negedge clk_i);
    start_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(i, vecs[i]);

    // Async reset mid-stall: INSTR_A (rs=9) is held, create a hazard, then
    // drop start_i between edges and expect immediate clearing.
    @(negedge clk_i);
    flush_i = 1'b0;
    clear_cnt_i = 1'b0;
    idex_memread_i = 1'b1;
    idex_rt_i = 5'd9;
    instr_i = INSTR_B;
    pc4_i = 32'd40;
    #1;
    checkOutput("midstall bubble", 32'(bubble_o), 32'd1);
    checkOutput("midstall pc_write", 32'(pc_write_o), 32'd0);
    #1;
    start_i = 1'b0;
    #1;
    checkRegs("async_rst", 32'h0, 32'h0, 1'b0, 2'd0, 2'd0);
    checkOutput("async_rst pc_write", 32'(pc_write_o), 32'd1);
    checkOutput("async_rst bubble", 32'(bubble_o), 32'd0);
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkRegs("post_rst", INSTR_B, 32'd40, 1'b1, 2'd0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
